// File: rtl/mdu.sv
// Multiply/divide unit beside the EX-stage ALU: fixed-latency mult/div into
// the architectural HI/LO registers, plus direct mthi/mtlo writes.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NONE7 = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_e      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    op_e         op_c;
    logic        is_md, is_mul, is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, quo, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    always_comb begin
        op_c      = op_e'(op);
        is_mul    = (op_c == OP_MULT) || (op_c == OP_MULTU);
        is_md     = is_mul || (op_c == OP_DIV) || (op_c == OP_DIVU);
        is_signed = (op_c == OP_MULT) || (op_c == OP_DIV);

        // Sign-extending into 64 bits lets one unsigned multiplier serve both
        // mult and multu: the low 64 bits of the product are identical.
        a_ext = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
        prod  = a_ext * b_ext;

        // Signed divide works on magnitudes, then restores signs; this also
        // yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing.
        a_neg = is_signed & A[31];
        b_neg = is_signed & B[31];
        a_mag = a_neg ? (~A + 32'd1) : A;
        b_mag = b_neg ? (~B + 32'd1) : B;
        b_div = (B == '0) ? 32'd1 : b_mag;
        quo   = a_mag / b_div;
        rem   = a_mag % b_div;

        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end else begin
            res_hi = a_neg ? (~rem + 32'd1) : rem;
            res_lo = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
            res_wr = (B != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && is_md) state_nx = S_RUN;
            S_RUN:   if (cnt == '0)      state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_RUN);
        stall_req = busy | (start & is_md);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= is_mul ? MULT_LOAD : DIV_LOAD;
                        end else if (op_c == OP_MTHI) begin
                            HI <= A;
                        end else if (op_c == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == '0) begin
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
